tree_node_loader: RTL and testbench

- Holds one decision tree's node table and fills it from a 32-bit host/DMA stream.
- Serves the table to the tree-walker over its node-fetch interface: node_index in, 64-bit node word out.
- Checks the structure of each node as it arrives and reports when the table is ready for the walker to start.

---
 rtl/tree_pkg.sv | 20 ++
 rtl/tree_node_ram.sv | 26 ++
 rtl/tree_node_loader.sv | 139 +++++++++++++
 tb/tb_tree_node_loader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared decision-tree node definitions used by the table loader and the tree walker.
package tree_pkg;

  typedef struct packed {
    logic [7:0]  f_index;
    logic [7:0]  leaf_or_node;
    logic [15:0] next_node_right_index;
    logic [31:0] value;
  } tree_camps_t;

  localparam logic [7:0] LEAF = 8'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX_LO  = 2'd1,
    RX_HI  = 2'd2,
    FINISH = 2'd3
  } loader_state_t;

endpackage

// File: rtl/tree_node_ram.sv
// Node table storage: one synchronous write port, one asynchronous read port.
// A read of the word being written in the same cycle returns the old contents.
module tree_node_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tree_node_loader.sv
// Loads a decision-tree node table from a 32-bit stream, checks node structure on the fly,
// and serves the table to the walker through a combinational read port.
module tree_node_loader
  import tree_pkg::*;
#(
  parameter int N_NODE_AND_LEAFS = 256,
  parameter int N_FEATURE        = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_start,
  input  logic [15:0]                         load_count,
  input  logic                                in_valid,
  input  logic [31:0]                         in_data,
  output logic                                in_ready,
  input  logic [$clog2(N_NODE_AND_LEAFS)-1:0] node_index,
  output logic [63:0]                         node,
  output logic                                tree_ready,
  output logic                                load_done,
  output logic                                load_error,
  output logic [15:0]                         err_node
);

  localparam int          IW    = $clog2(N_NODE_AND_LEAFS);
  localparam logic [31:0] NF    = 32'(N_FEATURE);
  localparam logic [16:0] N_MAX = 17'(N_NODE_AND_LEAFS);

  loader_state_t state_q;
  logic [15:0]   count_q;
  logic [15:0]   counter_q;
  logic [31:0]   lo_q;
  logic          in_ready_q;
  logic          tree_ready_q;
  logic          load_done_q;
  logic          load_error_q;
  logic [15:0]   err_node_q;

  tree_camps_t   wr_node;
  logic          beat;
  logic          last_node;
  logic          count_bad;
  logic          node_bad;
  logic [16:0]   counter_inc;

  assign beat        = in_valid && in_ready_q;
  assign wr_node     = tree_camps_t'({in_data, lo_q});
  assign last_node   = (counter_q == count_q - 16'd1);
  assign counter_inc = {1'b0, counter_q} + 17'd1;
  assign count_bad   = (load_count == 16'd0) || ({1'b0, load_count} > N_MAX);

  // Leaves carry no child pointers, so only decision nodes are checked.
  assign node_bad = (wr_node.leaf_or_node != LEAF) &&
                    (({24'd0, wr_node.f_index} >= NF) ||
                     (wr_node.next_node_right_index <= counter_q) ||
                     (wr_node.next_node_right_index >= count_q) ||
                     (counter_inc >= {1'b0, count_q}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= 16'd0;
      counter_q    <= 16'd0;
      lo_q         <= 32'd0;
      in_ready_q   <= 1'b0;
      tree_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      err_node_q   <= 16'd0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            count_q      <= load_count;
            counter_q    <= 16'd0;
            tree_ready_q <= 1'b0;
            load_error_q <= 1'b0;
            err_node_q   <= 16'd0;
            if (count_bad) begin
              load_error_q <= 1'b1;
              err_node_q   <= load_count;
              state_q      <= FINISH;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= RX_LO;
            end
          end
        end
        RX_LO: begin
          if (beat) begin
            lo_q    <= in_data;
            state_q <= RX_HI;
          end
        end
        RX_HI: begin
          if (beat) begin
            // Only the first failing node is reported; the stream is still drained.
            if (node_bad && !load_error_q) begin
              load_error_q <= 1'b1;
              err_node_q   <= counter_q;
            end
            if (last_node) begin
              in_ready_q <= 1'b0;
              state_q    <= FINISH;
            end else begin
              counter_q <= counter_q + 16'd1;
              state_q   <= RX_LO;
            end
          end
        end
        FINISH: begin
          load_done_q  <= 1'b1;
          tree_ready_q <= !load_error_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  tree_node_ram #(
    .DEPTH (N_NODE_AND_LEAFS),
    .WIDTH (64)
  ) u_ram (
    .clk     (clk),
    .we_i    (beat && (state_q == RX_HI)),
    .waddr_i (counter_q[IW-1:0]),
    .wdata_i (wr_node),
    .raddr_i (node_index),
    .rdata_o (node)
  );

  assign in_ready   = in_ready_q;
  assign tree_ready = tree_ready_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign err_node   = err_node_q;

endmodule

// File: tb/tb_tree_node_loader.sv
// Scenario bench for tree_node_loader: expected load results are queued at load_start and
// popped when load_done pulses; table contents are checked against a local copy.
module tb_tree_node_loader;

  localparam int N  = 256;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [15:0]   load_count = 16'd0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic [IW-1:0] node_index = '0;
  logic          in_ready, tree_ready, load_done, load_error;
  logic [63:0]   node;
  logic [15:0]   err_node;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        err;
    logic [15:0] enode;
    logic        ready;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] words [N];
  logic [63:0] model [N];

  always #5 clk = ~clk;

  tree_node_loader #(.N_NODE_AND_LEAFS(N), .N_FEATURE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_count (load_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .node_index (node_index),
    .node       (node),
    .tree_ready (tree_ready),
    .load_done  (load_done),
    .load_error (load_error),
    .err_node   (err_node)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [7:0] f, input logic [7:0] t,
                                     input logic [15:0] r, input logic [31:0] v);
    return {f, t, r, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] cnt);
    load_start = 1'b1;
    load_count = cnt;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input int stall);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL beat_accept: in_ready=%0b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    repeat (stall) tick();
  endtask

  task automatic stream(input int n, input int stall);
    for (int i = 0; i < n; i++) begin
      send_beat(words[i][31:0], stall);
      send_beat(words[i][63:32], (i == n - 1) ? 0 : stall);
      model[i] = words[i];
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (load_done !== 1'b1 && lat < 600) begin
      tick();
      lat++;
    end
    total++;
    if (load_done !== 1'b1) begin
      bad++;
      $display("FAIL load_done_timeout: load_done=%0b want=1", load_done);
    end
    $display("load complete lat=%0d error=%0b err_node=%0d tree_ready=%0b",
             lat, load_error, err_node, tree_ready);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({in_ready, tree_ready, load_done, load_error, err_node} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%0b tr=%0b done=%0b err=%0b en=%0d want all 0",
               in_ready, tree_ready, load_done, load_error, err_node);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_valid_tree();
    int   lat;
    exp_t e;
    words[0] = mk(8'd2, 8'd1, 16'd2, 32'd100);
    words[1] = mk(8'd0, 8'd0, 16'd0, 32'hFFFF_FFFB);
    words[2] = mk(8'd0, 8'd0, 16'd0, 32'd7);
    do_start(16'd3);
    sb.push_back('{err: 1'b0, enode: 16'd0, ready: 1'b1});
    stream(3, 0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL valid_latency: got=%0d want=1", lat);
    end
    total++;
    if ({load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL valid_result: got err=%0b en=%0d tr=%0b want err=%0b en=%0d tr=%0b",
               load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
    node_index = 8'd2;
    #1;
    total++;
    if (node !== 64'd7) begin
      bad++;
      $display("FAIL valid_read2: got=%h want=%h", node, 64'd7);
    end
    for (int i = 0; i < 2; i++) begin
      node_index = IW'(i);
      #1;
      total++;
      if (node !== model[i]) begin
        bad++;
        $display("FAIL valid_read%0d: got=%h want=%h", i, node, model[i]);
      end
    end
    tick();
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: load_done=%0b want=0", load_done);
    end
    repeat (4) tick();
    total++;
    if (tree_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_hold: tree_ready=%0b want=1", tree_ready);
    end
  endtask

  task automatic test_struct_errors();
    int   lat;
    exp_t e;
    words[0] = mk(8'd2, 8'd1, 16'd0, 32'd100);
    words[1] = mk(8'd0, 8'd0, 16'd0, 32'hFFFF_FFFB);
    words[2] = mk(8'd0, 8'd0, 16'd0, 32'd7);
    do_start(16'd3);
    sb.push_back('{err: 1'b1, enode: 16'd0, ready: 1'b0});
    stream(3, 0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if ({load_error, err_node, tree_ready} !== e || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL right_zero: got err=%0b en=%0d tr=%0b rdy=%0b want err=%0b en=%0d tr=%0b rdy=0",
               load_error, err_node, tree_ready, in_ready, e.err, e.enode, e.ready);
    end
    node_index = 8'd0;
    #1;
    total++;
    if (node !== model[0]) begin
      bad++;
      $display("FAIL right_zero_written: got=%h want=%h", node, model[0]);
    end
    // node1 bad feature index, node2 also bad: only the first is reported
    words[0] = mk(8'd2, 8'd1, 16'd2, 32'd100);
    words[1] = mk(8'd32, 8'd1, 16'd2, 32'd0);
    words[2] = mk(8'd0, 8'd1, 16'd0, 32'd7);
    do_start(16'd3);
    sb.push_back('{err: 1'b1, enode: 16'd1, ready: 1'b0});
    stream(3, 0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if ({load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL f_index_32: got err=%0b en=%0d tr=%0b want err=%0b en=%0d tr=%0b",
               load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
  endtask

  task automatic test_stalls();
    int   lat;
    exp_t e;
    words[0] = mk(8'd2, 8'd1, 16'd2, 32'd100);
    words[1] = mk(8'd0, 8'd0, 16'd0, 32'hFFFF_FFFB);
    words[2] = mk(8'd0, 8'd0, 16'd0, 32'd7);
    do_start(16'd3);
    sb.push_back('{err: 1'b0, enode: 16'd0, ready: 1'b1});
    stream(3, 3);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat != 1 || {load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL stall_result: got lat=%0d err=%0b en=%0d tr=%0b want lat=1 err=%0b en=%0d tr=%0b",
               lat, load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
    for (int i = 0; i < 3; i++) begin
      node_index = IW'(i);
      #1;
      total++;
      if (node !== model[i]) begin
        bad++;
        $display("FAIL stall_read%0d: got=%h want=%h", i, node, model[i]);
      end
    end
  endtask

  task automatic test_illegal_counts();
    int   lat;
    exp_t e;
    do_start(16'd0);
    sb.push_back('{err: 1'b1, enode: 16'd0, ready: 1'b0});
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL count0_ready: in_ready=%0b want=0", in_ready);
    end
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat != 1 || in_ready !== 1'b0 || {load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL count0: got lat=%0d rdy=%0b err=%0b en=%0d tr=%0b want lat=1 rdy=0 err=%0b en=%0d tr=%0b",
               lat, in_ready, load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
    do_start(16'd257);
    sb.push_back('{err: 1'b1, enode: 16'd257, ready: 1'b0});
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if ({load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL count257: got err=%0b en=%0d tr=%0b want err=%0b en=%0d tr=%0b",
               load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
    // largest legal count fills the whole table
    for (int i = 0; i < N; i++) words[i] = mk(8'd0, 8'd0, 16'd0, 32'(i * 3 + 1));
    do_start(16'd256);
    sb.push_back('{err: 1'b0, enode: 16'd0, ready: 1'b1});
    stream(N, 0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if ({load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL count256: got err=%0b en=%0d tr=%0b want err=%0b en=%0d tr=%0b",
               load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
    node_index = 8'd255;
    #1;
    total++;
    if (node !== model[255]) begin
      bad++;
      $display("FAIL count256_read255: got=%h want=%h", node, model[255]);
    end
  endtask

  task automatic test_reset_midload();
    int   lat;
    exp_t e;
    words[0] = mk(8'd1, 8'd1, 16'd2, 32'd55);
    words[1] = mk(8'd0, 8'd0, 16'd0, 32'd9);
    do_start(16'd4);
    send_beat(words[0][31:0], 0);
    send_beat(words[0][63:32], 0);
    model[0] = words[0];
    send_beat(words[1][31:0], 0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, tree_ready, load_done, load_error, err_node} !== 20'd0) begin
      bad++;
      $display("FAIL reset_midload: got rdy=%0b tr=%0b done=%0b err=%0b en=%0d want all 0",
               in_ready, tree_ready, load_done, load_error, err_node);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    words[0] = mk(8'd0, 8'd0, 16'd0, 32'h1234);
    do_start(16'd1);
    sb.push_back('{err: 1'b0, enode: 16'd0, ready: 1'b1});
    stream(1, 0);
    wait_done(lat);
    e = sb.pop_front();
    node_index = 8'd0;
    #1;
    total++;
    if ({load_error, err_node, tree_ready} !== e || node !== model[0]) begin
      bad++;
      $display("FAIL after_reset_load: got err=%0b en=%0d tr=%0b node=%h want err=%0b en=%0d tr=%0b node=%h",
               load_error, err_node, tree_ready, node, e.err, e.enode, e.ready, model[0]);
    end
  endtask

  task automatic test_reload();
    int   lat;
    exp_t e;
    words[0] = mk(8'd31, 8'd1, 16'd1, 32'd77);
    words[1] = mk(8'd0, 8'd0, 16'd0, 32'd88);
    do_start(16'd2);
    sb.push_back('{err: 1'b0, enode: 16'd0, ready: 1'b1});
    total++;
    if (tree_ready !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reload_start: got tr=%0b rdy=%0b want tr=0 rdy=1", tree_ready, in_ready);
    end
    do_start(16'd0);
    total++;
    if (in_ready !== 1'b1 || load_error !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored: got rdy=%0b err=%0b want rdy=1 err=0", in_ready, load_error);
    end
    stream(2, 0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if ({load_error, err_node, tree_ready} !== e) begin
      bad++;
      $display("FAIL reload_result: got err=%0b en=%0d tr=%0b want err=%0b en=%0d tr=%0b",
               load_error, err_node, tree_ready, e.err, e.enode, e.ready);
    end
  endtask

  initial begin
    test_reset();
    test_valid_tree();
    test_struct_errors();
    test_stalls();
    test_illegal_counts();
    test_reset_midload();
    test_reload();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
